// File: rtl/cic_rate_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | cic_rate_ctrl : CIC decimator ratio/reset sequencer and sample stream  |
// | Revision      : 1.0                                                    |
// +------------------------------------------------------------------------+
module cic_rate_ctrl #(
  parameter int DEF_RATIO      = 64,
  parameter int MIN_RATIO      = 2,
  parameter int MAX_RATIO      = 4096,
  parameter int FLUSH_CYCLES   = 8,
  parameter int SETTLE_SAMPLES = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              cfg_valid,
  input  logic [15:0]       cfg_ratio,
  output logic              cfg_ready,
  output logic              cfg_err,
  output logic              cic_rst,
  output logic [15:0]       cic_ratio,
  input  logic              cic_d_clk,
  input  logic signed [7:0] cic_d_out,
  output logic              smp_valid,
  output logic signed [7:0] smp_data,
  input  logic              smp_ready,
  output logic              running,
  output logic [7:0]        drop_cnt
);

  localparam int FCW = $clog2(FLUSH_CYCLES + 1);
  localparam int SCW = $clog2(SETTLE_SAMPLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [FCW-1:0] flush_cnt;
  logic [SCW-1:0] settle_cnt;
  logic           dclk_q;
  logic           dclk_rise;
  logic           xfer;
  logic           ratio_ok;
  logic           run_hold;

  assign dclk_rise = cic_d_clk & ~dclk_q;
  assign xfer      = cfg_valid & cfg_ready;
  assign ratio_ok  = ({16'd0, cfg_ratio} >= 32'(MIN_RATIO)) &&
                     ({16'd0, cfg_ratio} <= 32'(MAX_RATIO));
  assign run_hold  = (state == ST_RUN) && (state_nxt == ST_RUN);

  // Dropping enable beats everything; an accepted ratio restarts the flush.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   state_nxt = ST_FLUSH;
      ST_FLUSH:  if (flush_cnt == FCW'(FLUSH_CYCLES - 1)) state_nxt = ST_SETTLE;
      ST_SETTLE: if (dclk_rise && settle_cnt == SCW'(1)) state_nxt = ST_RUN;
      default:   state_nxt = ST_RUN;
    endcase
    if (xfer && ratio_ok && (state == ST_SETTLE || state == ST_RUN))
      state_nxt = ST_FLUSH;
    if (!enable)
      state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      flush_cnt  <= '0;
      settle_cnt <= SCW'(SETTLE_SAMPLES);
      dclk_q     <= 1'b0;
      cic_rst    <= 1'b1;
      cic_ratio  <= 16'(DEF_RATIO);
      cfg_ready  <= 1'b1;
      cfg_err    <= 1'b0;
      smp_valid  <= 1'b0;
      smp_data   <= '0;
      running    <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      dclk_q    <= cic_d_clk;
      cfg_err   <= xfer & ~ratio_ok;
      cic_rst   <= (state_nxt == ST_IDLE) || (state_nxt == ST_FLUSH);
      running   <= (state_nxt == ST_RUN);
      cfg_ready <= (state_nxt != ST_FLUSH);

      if (xfer && ratio_ok)
        cic_ratio <= cfg_ratio;

      if (state == ST_FLUSH && state_nxt == ST_FLUSH)
        flush_cnt <= flush_cnt + FCW'(1);
      else
        flush_cnt <= '0;

      if (state != ST_SETTLE)
        settle_cnt <= SCW'(SETTLE_SAMPLES);
      else if (dclk_rise)
        settle_cnt <= settle_cnt - SCW'(1);

      // Single-entry buffer: a fresh sample never overwrites an unconsumed one.
      if (run_hold) begin
        if (dclk_rise) begin
          if (!smp_valid || smp_ready) begin
            smp_data  <= cic_d_out;
            smp_valid <= 1'b1;
          end else if (drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
          end
        end else if (smp_ready) begin
          smp_valid <= 1'b0;
        end
      end else begin
        smp_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
